yarp_instr_encode: RTL and testbench

//  Streaming RV32I instruction encoder; inverse of the decode stage.
//  - Accepts instruction fields plus a format tag and packs them into a 32-bit instruction word.
//  - Tags each word with a word-aligned load address for instruction-memory preload and self-check benches.
//  - valid/ready on both sides; a 2-entry skid buffer gives full throughput with registered ready.

---
 rtl/yarp_instr_encode.sv | 167 ++++++++++++++++
 tb/tb_yarp_instr_encode.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarp_instr_encode.sv
`default_nettype none
// ============================================================================
// yarp_instr_encode : streaming RV32I field packer with load-address tagging
// Optional: YARP_ENC_IMM_CHECK_EN compiles in immediate range checking.
// Revision: 1.0
// ============================================================================
module yarp_instr_encode #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] addr_o,
  output logic        err_o
);

  localparam logic [2:0]  FMT_R     = 3'd0;
  localparam logic [2:0]  FMT_I     = 3'd1;
  localparam logic [2:0]  FMT_S     = 3'd2;
  localparam logic [2:0]  FMT_B     = 3'd3;
  localparam logic [2:0]  FMT_U     = 3'd4;
  localparam logic [2:0]  FMT_J     = 3'd5;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH_WORDS - 1));

  logic [31:0] enc_word;
  logic        enc_err;
  logic        imm_bad;

`ifdef YARP_ENC_IMM_CHECK_EN
  logic sx11;
  logic sx12;
  logic sx20;
  assign sx11 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign sx12 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign sx20 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  always_comb begin
    imm_bad = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: imm_bad = !sx11;
      FMT_B:        imm_bad = !sx12 || imm_i[0];
      FMT_U:        imm_bad = |imm_i[11:0];
      FMT_J:        imm_bad = !sx20 || imm_i[0];
      default:      imm_bad = 1'b0;
    endcase
  end
`else
  logic unused_imm0;
  assign unused_imm0 = imm_i[0];
  assign imm_bad     = 1'b0;
`endif

  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = imm_bad;
    case (fmt_i)
      FMT_R: enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
      FMT_I: enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
      FMT_S: enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
      FMT_B: enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                         imm_i[4:1], imm_i[11], op_i};
      FMT_U: enc_word = {imm_i[31:12], rd_i, op_i};
      FMT_J: enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
      default: enc_err = 1'b1;
    endcase
  end

  logic        main_valid_q, main_valid_d;
  logic [31:0] main_instr_q, main_instr_d;
  logic [31:0] main_addr_q,  main_addr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_addr_q,  skid_addr_d;
  logic        skid_err_q,   skid_err_d;
  logic [31:0] addr_cnt_q,   addr_cnt_d;
  logic        err_q,        err_d;
  logic        accept;
  logic        drain;

  assign accept = in_valid_i && !skid_valid_q;
  assign drain  = main_valid_q && out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_addr_d  = main_addr_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;
    skid_err_d   = skid_err_q;
    addr_cnt_d   = addr_cnt_q;
    err_d        = err_q;

    if (accept) begin
      addr_cnt_d = (addr_cnt_q == LAST_ADDR) ? BASE_ADDR : addr_cnt_q + 32'd4;
    end

    // The sticky error rises only when the offending word reaches the main register.
    if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_instr_d = skid_instr_q;
        main_addr_d  = skid_addr_q;
        err_d        = err_q | skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_instr_d = enc_word;
        main_addr_d  = addr_cnt_q;
        err_d        = err_q | enc_err;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_instr_d = enc_word;
      skid_addr_d  = addr_cnt_q;
      skid_err_d   = enc_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      main_instr_q <= 32'd0;
      main_addr_q  <= BASE_ADDR;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_addr_q  <= BASE_ADDR;
      skid_err_q   <= 1'b0;
      addr_cnt_q   <= BASE_ADDR;
      err_q        <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_addr_q  <= main_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
      skid_err_q   <= skid_err_d;
      addr_cnt_q   <= addr_cnt_d;
      err_q        <= err_d;
    end
  end

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign instr_o     = main_instr_q;
  assign addr_o      = main_addr_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_yarp_instr_encode.sv
`default_nettype none
// ============================================================================
// tb_yarp_instr_encode : scoreboard bench with a field-placement reference model
// Revision: 1.0
// ============================================================================
module tb_yarp_instr_encode;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  fmt_i = 3'd0;
  logic [6:0]  op_i = 7'd0;
  logic [4:0]  rd_i = 5'd0;
  logic [4:0]  rs1_i = 5'd0;
  logic [4:0]  rs2_i = 5'd0;
  logic [2:0]  funct3_i = 3'd0;
  logic [6:0]  funct7_i = 7'd0;
  logic [31:0] imm_i = 32'd0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] instr_o;
  logic [31:0] addr_o;
  logic        err_o;

  yarp_instr_encode #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .fmt_i(fmt_i), .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .instr_o(instr_o), .addr_o(addr_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl_addr = BASE;
  logic        mdl_err = 1'b0;
  bit          rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Extract w bits of v starting at src and move them to position dst.
  function automatic logic [31:0] place(input logic [31:0] v, input int src,
                                        input int w, input int dst);
    logic [63:0] t;
    logic [63:0] m;
    t = {32'd0, v};
    m = (64'd1 << w) - 64'd1;
    return 32'(((t >> src) & m) << dst);
  endfunction

  function automatic void model_word(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
      output logic [31:0] w, output bit bad);
    int s;
    s   = $signed(imm);
    bad = 1'b0;
    w   = place({25'd0, op}, 0, 7, 0);
    case (f)
      3'd0: w |= place({27'd0, rd}, 0, 5, 7) | place({29'd0, f3}, 0, 3, 12) |
                 place({27'd0, rs1}, 0, 5, 15) | place({27'd0, rs2}, 0, 5, 20) |
                 place({25'd0, f7}, 0, 7, 25);
      3'd1: w |= place({27'd0, rd}, 0, 5, 7) | place({29'd0, f3}, 0, 3, 12) |
                 place({27'd0, rs1}, 0, 5, 15) | place(imm, 0, 12, 20);
      3'd2: w |= place(imm, 0, 5, 7) | place({29'd0, f3}, 0, 3, 12) |
                 place({27'd0, rs1}, 0, 5, 15) | place({27'd0, rs2}, 0, 5, 20) |
                 place(imm, 5, 7, 25);
      3'd3: w |= place(imm, 11, 1, 7) | place(imm, 1, 4, 8) |
                 place({29'd0, f3}, 0, 3, 12) | place({27'd0, rs1}, 0, 5, 15) |
                 place({27'd0, rs2}, 0, 5, 20) | place(imm, 5, 6, 25) |
                 place(imm, 12, 1, 31);
      3'd4: w |= place({27'd0, rd}, 0, 5, 7) | place(imm, 12, 20, 12);
      3'd5: w |= place({27'd0, rd}, 0, 5, 7) | place(imm, 12, 8, 12) |
                 place(imm, 11, 1, 20) | place(imm, 1, 10, 21) | place(imm, 20, 1, 31);
      default: begin
        w   = 32'h0000_0013;
        bad = 1'b1;
      end
    endcase
`ifdef YARP_ENC_IMM_CHECK_EN
    case (f)
      3'd1, 3'd2: if (s < -2048 || s > 2047) bad = 1'b1;
      3'd3: if (s < -4096 || s > 4095 || imm[0]) bad = 1'b1;
      3'd4: if ((imm % 32'd4096) != 32'd0) bad = 1'b1;
      3'd5: if (s < -(1 << 20) || s > (1 << 20) - 1 || imm[0]) bad = 1'b1;
      default: ;
    endcase
`else
    if (s == 0) bad = bad;
`endif
  endfunction

  // Record the expected response for the word currently on the input fields.
  task automatic model_push(input bit use_gold, input logic [31:0] gold);
    exp_t        e;
    logic [31:0] w;
    bit          bad;
    model_word(fmt_i, op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, w, bad);
    mdl_err  = mdl_err | bad;
    e.instr  = use_gold ? gold : w;
    e.addr   = mdl_addr;
    e.err    = mdl_err;
    mdl_addr = ((mdl_addr - BASE + 32'd4) % (32'd4 * DEPTH)) + BASE;
    sb.push_back(e);
  endtask

  // Monitor: compare every output transfer and check hold stability under stall.
  logic [31:0] prev_instr = 32'd0;
  logic [31:0] prev_addr = 32'd0;
  bit          prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_instr", instr_o, prev_instr);
        check("hold_addr", addr_o, prev_addr);
      end
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("instr", instr_o, e.instr);
          check("addr", addr_o, e.addr);
          check("err", {31'd0, err_o}, {31'd0, e.err});
        end
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_instr = instr_o;
      prev_addr  = addr_o;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
  end

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    fmt_i = f; op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    funct3_i = f3; funct7_i = f7; imm_i = imm;
  endtask

  task automatic send(input bit use_gold, input logic [31:0] gold);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    while (!in_ready_o) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        in_valid_i = 1'b0;
        return;
      end
    end
    model_push(use_gold, gold);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain_wait();
    int n;
    in_valid_i = 1'b0;
    rand_rdy   = 1'b0;
    @(posedge clk); #2;
    out_ready_i = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    check("drain_left", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid_i = 1'b0;
    reset_n    = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("rst_instr", instr_o, 32'd0);
    check("rst_addr", addr_o, BASE);
    check("rst_err", {31'd0, err_o}, 32'd0);
    sb.delete();
    mdl_addr = BASE;
    mdl_err  = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic rand_fields(input int max_fmt);
    logic [31:0] t;
    logic [31:0] imm;
    t = $urandom;
    case ($urandom_range(0, 3))
      0: imm = $urandom;
      1: imm = {{20{t[11]}}, t[11:0]};
      2: imm = t & 32'hFFFF_F000;
      default: imm = {{11{t[20]}}, t[20:1], 1'b0};
    endcase
    set_fields(3'($urandom_range(0, max_fmt)), 7'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 3'($urandom), 7'($urandom), imm);
  endtask

  task automatic rand_phase(input int n, input int max_fmt);
    rand_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      rand_fields(max_fmt);
      send(1'b0, 32'd0);
    end
    drain_wait();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Golden words, one per format, with unused fields randomized.
    out_ready_i = 1'b1;
    set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'($urandom), 3'd0, 7'($urandom), 32'd5);
    send(1'b1, 32'h0050_0093);
    check("lat_I", {31'd0, out_valid_o}, 32'd1);
    set_fields(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, $urandom);
    send(1'b1, 32'h0020_81B3);
    check("lat_R", {31'd0, out_valid_o}, 32'd1);
    set_fields(3'd2, 7'h23, 5'($urandom), 5'd1, 5'd2, 3'd2, 7'($urandom), 32'd8);
    send(1'b1, 32'h0020_A423);
    set_fields(3'd3, 7'h63, 5'($urandom), 5'd0, 5'd0, 3'd0, 7'($urandom), 32'hFFFF_FFFC);
    send(1'b1, 32'hFE00_0EE3);
    set_fields(3'd5, 7'h6F, 5'd1, 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 32'h800);
    send(1'b1, 32'h0010_00EF);
    set_fields(3'd4, 7'h37, 5'd5, 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 32'h1234_5000);
    send(1'b1, 32'h1234_52B7);
    check("lat_U", {31'd0, out_valid_o}, 32'd1);
    drain_wait();

    // Backpressure: two accepted, third refused, then gap-free drain.
    do_reset();
    out_ready_i = 1'b0;
    set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid_i = 1'b1;
    check("bp_ready0", {31'd0, in_ready_o}, 32'd1);
    model_push(1'b0, 32'd0);
    @(posedge clk); #1;
    set_fields(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    check("bp_ready1", {31'd0, in_ready_o}, 32'd1);
    model_push(1'b0, 32'd0);
    @(posedge clk); #1;
    set_fields(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    check("bp_ready2", {31'd0, in_ready_o}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_stall_ready", {31'd0, in_ready_o}, 32'd0);
      check("bp_stall_valid", {31'd0, out_valid_o}, 32'd1);
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_nogap1", {31'd0, out_valid_o}, 32'd1);
    check("bp_reopen", {31'd0, in_ready_o}, 32'd1);
    model_push(1'b0, 32'd0);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    check("bp_nogap2", {31'd0, out_valid_o}, 32'd1);
    drain_wait();

    // Address wrap across five words with a four-word window.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_fields(3'd1, 7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
      send(1'b0, 32'd0);
    end
    drain_wait();

    // Out-of-range I-type immediate.
    do_reset();
    set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    send(1'b1, 32'h8000_0093);
    drain_wait();
`ifdef YARP_ENC_IMM_CHECK_EN
    check("imm_range_err", {31'd0, err_o}, 32'd1);
`else
    check("imm_range_err", {31'd0, err_o}, 32'd0);
`endif

    // Illegal format: NOP word and sticky error.
    do_reset();
    set_fields(3'd7, 7'h33, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, $urandom);
    send(1'b1, 32'h0000_0013);
    check("illegal_err_now", {31'd0, err_o}, 32'd1);
    idle(5);
    check("illegal_err_held", {31'd0, err_o}, 32'd1);
    drain_wait();

    // Reset with both entries occupied.
    do_reset();
    out_ready_i = 1'b0;
    rand_fields(5);
    send(1'b0, 32'd0);
    rand_fields(5);
    send(1'b0, 32'd0);
    in_valid_i = 1'b0;
    check("mid_full", {31'd0, in_ready_o}, 32'd0);
    do_reset();
    out_ready_i = 1'b1;
    set_fields(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 32'd0);
    send(1'b0, 32'd0);
    drain_wait();

    // Randomized streams: legal formats, then all formats.
    do_reset();
    rand_phase(300, 5);
    do_reset();
    rand_phase(300, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
